keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 passive matrix keypad.
- Drives one column low at a time and samples the four pulled-up row inputs.
- Debounces each of the 16 keys independently and presents a registered 16-bit pressed-key bitmap.
- Sits between the board keypad pins and the key-press keeper logic, which registers the bitmap every clock.

Parameters:
- SCAN_DWELL, 1024, clock cycles each column stays driven; minimum 4; rows sampled on the last dwell cycle.
- DEBOUNCE_SCANS, 4, consecutive identical full-frame samples required before a key's output bit changes; minimum 1.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous reset, active-high.
- column_pins  output  4  column drive, active-low, one-hot-low: exactly one bit is 0 at all times.
- row_pins  input  4  row sense, externally pulled up; 0 means a key in the driven column is pressed.
- keypad_read  output  16  debounced key bitmap; bit (4*col + row) = 1 while that key is held.

Behaviour:
- Reset (RST sampled high at a CLK edge):
  - column_pins = 4'b1110 (column 0 active).
  - keypad_read = 16'h0000.
  - Dwell counter, column index, synchronizer, raw frame and all debounce counters cleared.
  - Reset asserted mid-scan aborts the frame; scanning restarts at column 0, dwell cycle 0, on the first edge with RST low.
- Row synchronizer:
  - row_pins pass through a 2-flop synchronizer, then are inverted (pressed = 1).
  - Synchronizer flops reset to 4'b1111 (no press).
- Scan sequence:
  - Column index c cycles 0,1,2,3,0,… and column_pins = ~(1 << c).
  - The dwell counter counts 0..SCAN_DWELL-1.
  - On dwell count SCAN_DWELL-1, the synchronized inverted rows are stored into raw bits [4c+3:4c]. On the same edge the dwell counter wraps to 0 and c advances.
  - The column output changes on that same edge, so each column is driven for exactly SCAN_DWELL cycles.
  - The first 3 cycles of each dwell are settling plus synchronizer latency and are never sampled.
- Frame complete:
  - Asserted internally for one cycle when column 3's rows are stored.
  - Frame period = 4*SCAN_DWELL cycles.
- Per-key debounce (evaluated only on frame complete, all 16 keys in parallel):
  - If raw bit == current keypad_read bit: that key's counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_SCANS, the keypad_read bit toggles to the raw value and the counter clears.
  - Counter width = clog2(DEBOUNCE_SCANS+1).
  - A bounce (raw returns to the old value before the count is reached) clears the counter; the output never changes.
- Latency: a key stable from the start of a frame sets its output bit DEBOUNCE_SCANS frames later, on the frame-complete edge of the DEBOUNCE_SCANS-th frame. Release is symmetric.
- Multiple simultaneous keys are reported independently; no ghosting suppression or priority is applied.
- keypad_read is a register, glitch-free, and changes only on frame-complete edges.
- column_pins is a register; no combinational path from row_pins to any output.

Test Plan:
- Reset and idle:
  - Stimulus: RST high 2 cycles, SCAN_DWELL=4, no keys pressed.
  - Response: column_pins=1110 during reset; after release column_pins follows 1110→1101→1011→0111 every 4 cycles; keypad_read stays 0000 for 20 frames.
- Single press:
  - Stimulus: keypad model grounds row 2 whenever column 1 is low (key index 6); DEBOUNCE_SCANS=3, pressed from frame start.
  - Response: keypad_read=0x0040 after exactly 3 frames (48 cycles); on release it returns to 0x0000 after 3 more frames.
- Bounce rejection:
  - Stimulus: key 0 pressed for 2 frames, released for 1 frame, repeated 5 times; DEBOUNCE_SCANS=3.
  - Response: keypad_read bit 0 never sets.
- Multi-key:
  - Stimulus: keys 0, 5, 10 and 15 held together.
  - Response: keypad_read=0x8421 after DEBOUNCE_SCANS frames.
- Corner key and wrap:
  - Stimulus: key 15 only (column 3, row 3).
  - Response: keypad_read=0x8000; column index wraps cleanly from 3 to 0 with no extra cycle.
- Reset mid-operation:
  - Stimulus: key 6 debounced (keypad_read=0x0040), RST pulsed 1 cycle mid-dwell of column 2.
  - Response: next cycle keypad_read=0000 and column_pins=1110; bit 6 reasserts DEBOUNCE_SCANS frames later.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 passive matrix keypad by driving one column low at a time,
//   samples the pulled-up rows through a 2-flop synchronizer, and debounces
//   every key independently into a registered 16-bit pressed-key bitmap.
//
// Ports
//   CLK          system clock, all logic on its rising edge
//   RST          synchronous reset, active-high
//   column_pins  column drive, active-low, exactly one bit low at all times
//   row_pins     row sense, pulled up externally, 0 = key pressed in driven column
//   keypad_read  debounced bitmap, bit (4*col + row) = 1 while the key is held
//
// Parameters
//   SCAN_DWELL      cycles each column stays driven (>= 4); rows are sampled
//                   on the last dwell cycle
//   DEBOUNCE_SCANS  consecutive differing full-frame samples needed before a
//                   key's output bit changes (>= 1)
module keypad_scanner #(
   parameter int SCAN_DWELL     = 1024,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [3:0]  column_pins,
   input  logic [3:0]  row_pins,
   output logic [15:0] keypad_read
);

   localparam int DW = $clog2(SCAN_DWELL);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_SCANS - 1);

   logic [3:0]    sync1_reg;
   logic [3:0]    sync2_reg;
   logic [DW-1:0] dwell_reg;
   logic [1:0]    col_reg;
   // Only columns 0..2 need storage: column 3's rows feed the debouncers
   // directly on the frame-complete edge.
   logic [11:0]   raw_reg;

   logic          sample_now;
   logic          frame_done;
   logic [3:0]    rows_pressed;
   logic [15:0]   frame_raw;

   assign sample_now   = (dwell_reg == DWELL_LAST);
   assign frame_done   = sample_now && (col_reg == 2'd3);
   assign rows_pressed = ~sync2_reg;
   assign frame_raw    = {rows_pressed, raw_reg};

   // Scan sequencer, synchronizer and raw frame capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_reg   <= 4'b1111;
         sync2_reg   <= 4'b1111;
         dwell_reg   <= '0;
         col_reg     <= 2'd0;
         raw_reg     <= '0;
         column_pins <= 4'b1110;
      end else begin
         sync1_reg <= row_pins;
         sync2_reg <= sync1_reg;
         if (sample_now) begin
            dwell_reg   <= '0;
            col_reg     <= col_reg + 2'd1;
            // Rotating the low bit keeps column_pins = ~(1 << col) and
            // moves the drive on the same edge the rows are captured.
            column_pins <= {column_pins[2:0], column_pins[3]};
            case (col_reg)
               2'd0:    raw_reg[3:0]  <= rows_pressed;
               2'd1:    raw_reg[7:4]  <= rows_pressed;
               2'd2:    raw_reg[11:8] <= rows_pressed;
               default: ;
            endcase
         end else begin
            dwell_reg <= dwell_reg + 1'b1;
         end
      end
   end

   // Per-key debounce, evaluated once per completed frame
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_key
         logic          key_reg;
         logic [CW-1:0] cnt_reg;

         always_ff @(posedge CLK) begin
            if (RST) begin
               key_reg <= 1'b0;
               cnt_reg <= '0;
            end else if (frame_done) begin
               if (frame_raw[gi] == key_reg) begin
                  // Agreement (or a bounce back) restarts the count
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  key_reg <= frame_raw[gi];
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign keypad_read[gi] = key_reg;
      end
   endgenerate

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   localparam int SCAN_DWELL     = 4;
   localparam int DEBOUNCE_SCANS = 3;
   localparam int FRAME          = 4 * SCAN_DWELL;
   localparam int LAT            = DEBOUNCE_SCANS * FRAME;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  column_pins;
   logic [3:0]  row_pins;
   logic [15:0] keypad_read;

   logic [15:0] pressed    = 16'h0000;
   logic [15:0] model_read = 16'h0000;
   logic [15:0] prev_read  = 16'h0000;
   int          cyc        = 0;
   int          rel_cyc    = 0;
   int          errors     = 0;
   int          checks     = 0;
   bit          mon_en     = 1'b0;

   typedef struct {
      logic [15:0] val;
      int          due;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   keypad_scanner #(
      .SCAN_DWELL     (SCAN_DWELL),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .column_pins (column_pins),
      .row_pins    (row_pins),
      .keypad_read (keypad_read)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Passive matrix: a pressed key shorts its row to its column
   always_comb begin
      row_pins = 4'b1111;
      for (int c = 0; c < 4; c++)
         if (column_pins[c] == 1'b0)
            for (int r = 0; r < 4; r++)
               if (pressed[4*c+r]) row_pins[r] = 1'b0;
   end

   // Scoreboard consumer: every change of keypad_read must match the next
   // expected value and arrive on exactly the expected cycle.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (keypad_read !== prev_read) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: keypad_read=%h at cycle %0d, expected no change", keypad_read, cyc);
            end else begin
               mon_e = sb_q.pop_front();
               if (keypad_read !== mon_e.val || cyc != mon_e.due) begin
                  errors++;
                  $display("FAIL sb_change: got %h at cycle %0d, expected %h at cycle %0d",
                           keypad_read, cyc, mon_e.val, mon_e.due);
               end else begin
                  $display("change ok: keypad_read=%h at cycle %0d", keypad_read, cyc);
               end
            end
         end
         prev_read = keypad_read;
      end
   end

   task automatic push_exp(input logic [15:0] val, input int due);
      exp_t e;
      e.val = val;
      e.due = due;
      sb_q.push_back(e);
      model_read = val;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge CLK);
   endtask

   // Two-cycle reset; rel_cyc is the cycle count at release
   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b1;
      if (model_read != 16'h0000) push_exp(16'h0000, cyc + 1);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      int idx;
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         checks++;
         if (column_pins !== 4'b1110) begin
            errors++;
            $display("FAIL reset_col: column_pins=%b required 1110", column_pins);
         end
         checks++;
         if (keypad_read !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read: keypad_read=%h required 0000", keypad_read);
         end
      end
      RST = 1'b0;
      rel_cyc   = cyc;
      prev_read = keypad_read;
      mon_en    = 1'b1;
      for (int n = 0; n < 20 * FRAME; n++) begin
         idx     = ((cyc - rel_cyc) / SCAN_DWELL) % 4;
         exp_col = ~(4'b0001 << idx);
         checks++;
         if (column_pins !== exp_col) begin
            errors++;
            $display("FAIL idle_col: column_pins=%b required %b at cycle %0d", column_pins, exp_col, cyc);
         end
         @(negedge CLK);
      end
      checks++;
      if (keypad_read !== 16'h0000) begin
         errors++;
         $display("FAIL idle_read: keypad_read=%h required 0000", keypad_read);
      end
      $display("test_reset done at cycle %0d", cyc);
   endtask

   task automatic test_single_press();
      apply_reset();
      pressed = 16'h0040;
      push_exp(16'h0040, rel_cyc + LAT);
      wait_to(rel_cyc + LAT - 1);
      checks++;
      if (keypad_read !== 16'h0000) begin
         errors++;
         $display("FAIL press_early: keypad_read=%h required 0000", keypad_read);
      end
      wait_to(rel_cyc + LAT);
      checks++;
      if (keypad_read !== 16'h0040) begin
         errors++;
         $display("FAIL press_set: keypad_read=%h required 0040", keypad_read);
      end
      pressed = 16'h0000;
      push_exp(16'h0000, rel_cyc + 2 * LAT);
      wait_to(rel_cyc + 2 * LAT - 1);
      checks++;
      if (keypad_read !== 16'h0040) begin
         errors++;
         $display("FAIL release_early: keypad_read=%h required 0040", keypad_read);
      end
      wait_to(rel_cyc + 2 * LAT + FRAME);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL single_missing: %0d expected changes pending, required 0", sb_q.size());
      end
      $display("test_single_press done at cycle %0d", cyc);
   endtask

   task automatic test_bounce();
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         pressed = 16'h0001;
         wait_to(rel_cyc + (3 * k + 2) * FRAME);
         pressed = 16'h0000;
         wait_to(rel_cyc + (3 * k + 3) * FRAME);
      end
      wait_to(cyc + 2 * FRAME);
      checks++;
      if (keypad_read !== 16'h0000) begin
         errors++;
         $display("FAIL bounce_read: keypad_read=%h required 0000", keypad_read);
      end
      $display("test_bounce done at cycle %0d", cyc);
   endtask

   task automatic test_multi_key();
      apply_reset();
      pressed = 16'h8421;
      push_exp(16'h8421, rel_cyc + LAT);
      wait_to(rel_cyc + LAT);
      checks++;
      if (keypad_read !== 16'h8421) begin
         errors++;
         $display("FAIL multi_set: keypad_read=%h required 8421", keypad_read);
      end
      pressed = 16'h0000;
      push_exp(16'h0000, rel_cyc + 2 * LAT);
      wait_to(rel_cyc + 2 * LAT + FRAME);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL multi_missing: %0d expected changes pending, required 0", sb_q.size());
      end
      $display("test_multi_key done at cycle %0d", cyc);
   endtask

   task automatic test_corner_wrap();
      logic [3:0] exp_col;
      int idx;
      apply_reset();
      pressed = 16'h8000;
      push_exp(16'h8000, rel_cyc + LAT);
      while (cyc < rel_cyc + LAT + FRAME) begin
         idx     = ((cyc - rel_cyc) / SCAN_DWELL) % 4;
         exp_col = ~(4'b0001 << idx);
         checks++;
         if (column_pins !== exp_col) begin
            errors++;
            $display("FAIL wrap_col: column_pins=%b required %b at cycle %0d", column_pins, exp_col, cyc);
         end
         @(negedge CLK);
      end
      checks++;
      if (keypad_read !== 16'h8000) begin
         errors++;
         $display("FAIL corner_set: keypad_read=%h required 8000", keypad_read);
      end
      pressed = 16'h0000;
      push_exp(16'h0000, rel_cyc + 2 * LAT + FRAME);
      wait_to(rel_cyc + 3 * LAT);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL corner_missing: %0d expected changes pending, required 0", sb_q.size());
      end
      $display("test_corner_wrap done at cycle %0d", cyc);
   endtask

   task automatic test_reset_mid();
      int x;
      apply_reset();
      pressed = 16'h0040;
      push_exp(16'h0040, rel_cyc + LAT);
      x = rel_cyc + LAT + 9;
      wait_to(x);
      checks++;
      if (column_pins !== 4'b1011) begin
         errors++;
         $display("FAIL mid_col2: column_pins=%b required 1011", column_pins);
      end
      RST = 1'b1;
      push_exp(16'h0000, x + 1);
      @(negedge CLK);
      checks++;
      if (keypad_read !== 16'h0000) begin
         errors++;
         $display("FAIL mid_read: keypad_read=%h required 0000", keypad_read);
      end
      checks++;
      if (column_pins !== 4'b1110) begin
         errors++;
         $display("FAIL mid_col: column_pins=%b required 1110", column_pins);
      end
      RST = 1'b0;
      rel_cyc = cyc;
      push_exp(16'h0040, rel_cyc + LAT);
      wait_to(rel_cyc + LAT - 1);
      checks++;
      if (keypad_read !== 16'h0000) begin
         errors++;
         $display("FAIL mid_early: keypad_read=%h required 0000", keypad_read);
      end
      wait_to(rel_cyc + LAT);
      checks++;
      if (keypad_read !== 16'h0040) begin
         errors++;
         $display("FAIL mid_reassert: keypad_read=%h required 0040", keypad_read);
      end
      pressed = 16'h0000;
      push_exp(16'h0000, rel_cyc + 2 * LAT);
      wait_to(rel_cyc + 2 * LAT + FRAME);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL mid_missing: %0d expected changes pending, required 0", sb_q.size());
      end
      $display("test_reset_mid done at cycle %0d", cyc);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi_key();
      test_corner_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
